// File: rtl/seg_scan_mux.sv
// Time-multiplexed 7-segment scanner: per-digit enable, PWM brightness, dead time, output polarity.
// Latency: outputs registered one cycle after scan state; no backpressure, free-running scan.
module seg_scan_mux #(
   parameter int DIGITS        = 4,
   parameter int SEG_W         = 8,
   parameter int CLK_DIV       = 416,
   parameter int DEAD_CYC      = 2,
   parameter int DUTY_W        = 4,
   parameter int ANODE_ACT_LOW = 0,
   parameter int SEG_ACT_LOW   = 0
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [DIGITS*SEG_W-1:0]   seg_bus,
   input  logic [DIGITS-1:0]         digit_en,
   input  logic [DUTY_W-1:0]         brightness,
   output logic [SEG_W-1:0]          seg,
   output logic [DIGITS-1:0]         anode,
   output logic                      frame_tick
);

   localparam int CW = $clog2(CLK_DIV);
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int OW = CW + 1;
   localparam int PW = DUTY_W + OW;
   localparam logic [DIGITS-1:0] AN_OFF  = {DIGITS{(ANODE_ACT_LOW != 0)}};
   localparam logic [SEG_W-1:0]  SEG_OFF = {SEG_W{(SEG_ACT_LOW != 0)}};

   logic [CW-1:0]     div_cnt;
   logic [IW-1:0]     idx;
   logic [SEG_W-1:0]  seg_lat;
   logic              en_lat;
   logic [DUTY_W-1:0] bright_r;

   logic              slot_start;
   logic              slot_end;
   logic              last_digit;
   logic [SEG_W-1:0]  seg_cur;
   logic              en_cur;
   logic [SEG_W-1:0]  seg_eff;
   logic              en_eff;
   logic [DUTY_W-1:0] bright_eff;
   logic [PW-1:0]     prod;
   logic [OW-1:0]     on_end;
   logic              lit;
   logic [DIGITS-1:0] anode_nxt;

   // Values latched at slot start are forwarded in that same cycle so that a
   // zero dead time still lights k=0 with the new digit's data.
   always_comb begin
      slot_start = (div_cnt == '0);
      slot_end   = (div_cnt == CW'(CLK_DIV - 1));
      last_digit = (idx == IW'(DIGITS - 1));
      seg_cur    = seg_bus[idx*SEG_W +: SEG_W];
      en_cur     = digit_en[idx];
      seg_eff    = slot_start ? seg_cur : seg_lat;
      en_eff     = slot_start ? en_cur : en_lat;
      bright_eff = (slot_start && idx == '0) ? brightness : bright_r;
      prod       = PW'(bright_eff) * PW'(CLK_DIV - DEAD_CYC);
      on_end     = (&bright_eff) ? OW'(CLK_DIV) : OW'(DEAD_CYC) + OW'(prod >> DUTY_W);
      lit        = en_eff && ({1'b0, div_cnt} >= OW'(DEAD_CYC)) && ({1'b0, div_cnt} < on_end);
      anode_nxt  = lit ? (DIGITS'(1) << idx) : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt    <= '0;
         idx        <= '0;
         seg_lat    <= '0;
         en_lat     <= 1'b0;
         bright_r   <= '0;
         seg        <= SEG_OFF;
         anode      <= AN_OFF;
         frame_tick <= 1'b0;
      end else begin
         div_cnt <= slot_end ? '0 : div_cnt + 1'b1;
         if (slot_end)
            idx <= last_digit ? '0 : idx + 1'b1;
         if (slot_start) begin
            seg_lat <= seg_cur;
            en_lat  <= en_cur;
         end
         // Brightness is sampled only at frame start so a frame never mixes duties.
         if (slot_start && idx == '0)
            bright_r <= brightness;
         seg        <= seg_eff ^ SEG_OFF;
         anode      <= anode_nxt ^ AN_OFF;
         frame_tick <= slot_end && last_digit;
      end
   end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Bench for seg_scan_mux: cycle scoreboard on an active-high instance plus
// directed slot/frame counts, and an active-low instance for async reset.
module tb_seg_scan_mux;

   localparam int D  = 4;
   localparam int CD = 16;
   localparam int DC = 2;
   localparam int DW = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        rst_n_b = 1'b1;
   logic [31:0] seg_bus;
   logic [3:0]  digit_en;
   logic [3:0]  brightness;
   logic [7:0]  seg, seg_b;
   logic [3:0]  anode, anode_b;
   logic        frame_tick, tick_b;

   int vec_cnt = 0;
   int err_cnt = 0;

   always #5 clk = ~clk;

   seg_scan_mux #(.DIGITS(D), .SEG_W(8), .CLK_DIV(CD), .DEAD_CYC(DC), .DUTY_W(DW),
                  .ANODE_ACT_LOW(0), .SEG_ACT_LOW(0)) u_dut (
      .clk(clk), .rst_n(rst_n), .seg_bus(seg_bus), .digit_en(digit_en),
      .brightness(brightness), .seg(seg), .anode(anode), .frame_tick(frame_tick));

   seg_scan_mux #(.DIGITS(D), .SEG_W(8), .CLK_DIV(CD), .DEAD_CYC(DC), .DUTY_W(DW),
                  .ANODE_ACT_LOW(1), .SEG_ACT_LOW(1)) u_dut_b (
      .clk(clk), .rst_n(rst_n_b), .seg_bus(seg_bus), .digit_en(digit_en),
      .brightness(brightness), .seg(seg_b), .anode(anode_b), .frame_tick(tick_b));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_cnt++;
      assert (got === exp) else begin
         err_cnt++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference model: expected {anode, seg, frame_tick} pushed each edge.
   int          m_cnt, m_idx, m_on_end;
   logic [7:0]  m_seg;
   logic        m_en, m_lit;
   logic [3:0]  m_br, m_an;
   logic [12:0] exp_q[$];
   logic [12:0] sb_e;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_cnt = 0; m_idx = 0; m_seg = 8'h00; m_en = 1'b0; m_br = 4'h0;
         exp_q.delete();
      end else begin
         if (m_cnt == 0) begin
            m_seg = seg_bus[m_idx*8 +: 8];
            m_en  = digit_en[m_idx];
            if (m_idx == 0) m_br = brightness;
         end
         m_on_end = (m_br == 4'hF) ? CD : DC + ((int'(m_br) * (CD - DC)) >> DW);
         m_lit    = m_en && (m_cnt >= DC) && (m_cnt < m_on_end);
         m_an     = m_lit ? 4'(1 << m_idx) : 4'h0;
         exp_q.push_back({m_an, m_seg, (m_cnt == CD - 1) && (m_idx == D - 1)});
         if (m_cnt == CD - 1) begin
            m_cnt = 0;
            m_idx = (m_idx + 1) % D;
         end else begin
            m_cnt++;
         end
      end
   end

   always @(posedge clk) begin
      #1;
      if (rst_n && exp_q.size() > 0) begin
         sb_e = exp_q.pop_front();
         chk("sb_anode", 32'(anode), 32'(sb_e[12:9]));
         chk("sb_seg", 32'(seg), 32'(sb_e[8:1]));
         chk("sb_tick", 32'(frame_tick), 32'(sb_e[0]));
      end
   end

   int         an_cnt[4];
   int         an_other, tick_cnt, seg_hits;
   int         cyc = 0;
   int         last_tick = -1;
   logic [7:0] tgt;

   task automatic clr();
      for (int i = 0; i < 4; i++) an_cnt[i] = 0;
      an_other = 0; tick_cnt = 0; seg_hits = 0;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #2;
         cyc++;
         case (anode)
            4'b0000: ;
            4'b0001: an_cnt[0]++;
            4'b0010: an_cnt[1]++;
            4'b0100: an_cnt[2]++;
            4'b1000: an_cnt[3]++;
            default: an_other++;
         endcase
         if (seg === tgt) seg_hits++;
         if (frame_tick === 1'b1) begin
            tick_cnt++;
            if (last_tick >= 0) chk("tick_period", 32'(cyc - last_tick), 32'd64);
            last_tick = cyc;
         end
      end
   endtask

   int n_wait;

   initial begin
      seg_bus    = 32'h44332211;
      digit_en   = 4'hF;
      brightness = 4'hF;
      tgt        = 8'h11;
      #1;
      rst_n   = 1'b0;
      rst_n_b = 1'b0;
      #2;
      chk("rst_anode", 32'(anode), 32'h0);
      chk("rst_seg", 32'(seg), 32'h0);
      chk("rst_tick", 32'(frame_tick), 32'h0);
      chk("rst_anode_b", 32'(anode_b), 32'hF);
      chk("rst_seg_b", 32'(seg_b), 32'hFF);
      @(negedge clk);
      rst_n   = 1'b1;
      rst_n_b = 1'b1;

      // Full brightness, all digits: 14 lit cycles per slot.
      clr(); run(128);
      for (int i = 0; i < 4; i++) chk("full_an_cnt", 32'(an_cnt[i]), 32'd28);
      chk("full_an_other", 32'(an_other), 32'd0);
      chk("full_ticks", 32'(tick_cnt), 32'd2);
      chk("full_seg11", 32'(seg_hits), 32'd32);

      // Half brightness: on_end=9, 7 lit cycles; mid-frame change waits for frame start.
      brightness = 4'h8;
      clr(); run(64);
      for (int i = 0; i < 4; i++) chk("b8_an_cnt", 32'(an_cnt[i]), 32'd7);
      clr(); run(24);
      brightness = 4'hF;
      run(40);
      for (int i = 0; i < 4; i++) chk("b8_mid_an_cnt", 32'(an_cnt[i]), 32'd7);
      clr(); run(64);
      for (int i = 0; i < 4; i++) chk("b15_after_an_cnt", 32'(an_cnt[i]), 32'd14);

      // Brightness zero: dark but scanning.
      brightness = 4'h0;
      tgt = 8'h33;
      clr(); run(128);
      chk("b0_an_sum", 32'(an_cnt[0] + an_cnt[1] + an_cnt[2] + an_cnt[3] + an_other), 32'd0);
      chk("b0_ticks", 32'(tick_cnt), 32'd2);
      chk("b0_seg33", 32'(seg_hits), 32'd32);

      // Digit 2 disabled.
      brightness = 4'hF;
      digit_en = 4'b1011;
      clr(); run(128);
      chk("en_an0", 32'(an_cnt[0]), 32'd28);
      chk("en_an1", 32'(an_cnt[1]), 32'd28);
      chk("en_an2", 32'(an_cnt[2]), 32'd0);
      chk("en_an3", 32'(an_cnt[3]), 32'd28);
      chk("en_ticks", 32'(tick_cnt), 32'd2);

      // Digit 1 data changed at k=5 of slot 1.
      digit_en = 4'hF;
      clr(); run(21);
      seg_bus = 32'h4433AA11;
      tgt = 8'h22;
      clr(); run(11);
      chk("midslot_seg22", 32'(seg_hits), 32'd11);
      tgt = 8'hAA;
      clr(); run(32);
      chk("midslot_noAA", 32'(seg_hits), 32'd0);
      clr(); run(32);
      chk("next_frame_AA", 32'(seg_hits), 32'd16);
      chk("next_frame_an1", 32'(an_cnt[1]), 32'd14);

      // Active-low instance: async reset mid-slot, then restart from digit 0.
      chk("b_pre_anode", 32'(anode_b), 32'hD);
      chk("b_pre_seg", 32'(seg_b), 32'h55);
      @(negedge clk);
      #3;
      rst_n_b = 1'b0;
      #1;
      chk("b_async_anode", 32'(anode_b), 32'hF);
      chk("b_async_seg", 32'(seg_b), 32'hFF);
      chk("b_async_tick", 32'(tick_b), 32'h0);
      @(negedge clk);
      rst_n_b = 1'b1;
      n_wait = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         n_wait++;
         if (anode_b !== 4'hF) break;
      end
      chk("b_first_lit_cycle", 32'(n_wait), 32'd3);
      chk("b_first_anode", 32'(anode_b), 32'hE);
      chk("b_first_seg", 32'(seg_b), 32'hEE);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
